// File: rtl/sat_addsub_hs.sv
// Signed add/subtract unit with saturate or wrap mode, valid/ready handshake on both sides,
// per-result overflow direction, a sticky overflow flag and a saturating overflow counter.
module sat_addsub_hs #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             ovf_neg,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [1:0]       mode_reg;
    logic [WIDTH:0]   sum_reg;

    logic             ovf_next;
    logic             ovf_neg_next;
    logic [WIDTH-1:0] result_next;
    logic             ovf_event;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = EXEC;
            end
            EXEC: state_next = SAT;
            SAT:  state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The extra top bit of the sum disagrees with the result sign bit exactly on overflow.
    always_comb begin
        ovf_next     = sum_reg[WIDTH] ^ sum_reg[WIDTH-1];
        ovf_neg_next = sum_reg[WIDTH] & ovf_next;
        result_next  = sum_reg[WIDTH-1:0];
        if (ovf_next && !mode_reg[1]) begin
            result_next = ovf_neg_next ? MIN_VAL : MAX_VAL;
        end
    end

    assign ovf_event = (state_reg == SAT) && ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            mode_reg  <= '0;
            sum_reg   <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            ovf_neg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                x_reg    <= x;
                y_reg    <= y;
                mode_reg <= mode;
            end
            if (state_reg == EXEC) begin
                if (mode_reg[0]) sum_reg <= {x_reg[WIDTH-1], x_reg} - {y_reg[WIDTH-1], y_reg};
                else             sum_reg <= {x_reg[WIDTH-1], x_reg} + {y_reg[WIDTH-1], y_reg};
            end
            if (state_reg == SAT) begin
                result  <= result_next;
                ovf     <= ovf_next;
                ovf_neg <= ovf_neg_next;
            end
        end
    end

    // A clear coinciding with an overflow event restarts the tally at that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (clr_ovf) begin
            sticky_ovf <= ovf_event;
            ovf_count  <= ovf_event ? CNT_W'(1) : '0;
        end else if (ovf_event) begin
            sticky_ovf <= 1'b1;
            if (!(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sat_addsub_hs.sv
// Scoreboard bench for sat_addsub_hs: the driver pushes model results, a monitor pops them
// at each output handshake.
module tb_sat_addsub_hs;

    localparam int WIDTH = 16;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             ovf_neg;
    logic             sticky_ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             clr_ovf = 1'b0;

    sat_addsub_hs #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .ovf_neg(ovf_neg), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             o;
        logic             n;
        logic             st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   txn = 0;
    int   rmode = 0;        // 0 random out_ready, 1 held low, 2 held high
    bit   m_sticky = 1'b0;
    int   m_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then the saturation/wrap rule.
    function automatic exp_t model(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                                   input logic [1:0] mv, input bit clr);
        exp_t e;
        int a, b, r, maxv, minv;
        bit ov, ng;
        a = int'($signed(xv));
        b = int'($signed(yv));
        r = mv[0] ? a - b : a + b;
        maxv = (1 << (WIDTH - 1)) - 1;
        minv = -(1 << (WIDTH - 1));
        ov = (r > maxv) || (r < minv);
        ng = (r < minv);
        if (ov && !mv[1]) e.res = ng ? WIDTH'(minv) : WIDTH'(maxv);
        else              e.res = r[WIDTH-1:0];
        e.o = ov;
        e.n = ng;
        if (clr) begin
            m_sticky = ov;
            m_count  = ov ? 1 : 0;
        end else if (ov) begin
            m_sticky = 1'b1;
            m_count  = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
        end
        e.st  = m_sticky;
        e.cnt = CNT_W'(m_count);
        return e;
    endfunction

    always begin
        @(posedge clk);
        #1;
        case (rmode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(result), 32'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                txn++;
                $display("txn %0d: result=%h ovf=%b neg=%b sticky=%b count=%0d (exp %h %b %b %b %0d)",
                         txn, result, ovf, ovf_neg, sticky_ovf, ovf_count,
                         e.res, e.o, e.n, e.st, e.cnt);
                chk("result", 32'(result), 32'(e.res));
                chk("ovf", 32'(ovf), 32'(e.o));
                chk("ovf_neg", 32'(ovf_neg), 32'(e.n));
                chk("sticky_ovf", 32'(sticky_ovf), 32'(e.st));
                chk("ovf_count", 32'(ovf_count), 32'(e.cnt));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                        input logic [1:0] mv, input bit clr_sat);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = xv;
        y = yv;
        mode = mv;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);             // accept edge k
        #1;
        in_valid = 1'b0;
        x = WIDTH'($urandom);
        y = WIDTH'($urandom);
        mode = 2'($urandom);
        q.push_back(model(xv, yv, mv, clr_sat));
        @(negedge clk);
        chk("lat_k_valid", 32'(out_valid), 32'd0);
        chk("busy_ready", 32'(in_ready), 32'd0);
        @(posedge clk);             // edge k+1
        #1;
        if (clr_sat) clr_ovf = 1'b1;
        @(negedge clk);
        chk("lat_k1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);             // edge k+2, SAT
        #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("lat_k2_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic clear_flags();
        wait_idle();
        @(posedge clk);
        #1;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        m_sticky = 1'b0;
        m_count = 0;
        @(negedge clk);
        chk("clr_sticky", 32'(sticky_ovf), 32'd0);
        chk("clr_count", 32'(ovf_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] ext[5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001};

    initial begin
        logic [WIDTH-1:0] xv, yv;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Positive saturation, then negative overflow in saturate and wrap modes.
        send(16'h7000, 16'h2000, 2'b00, 1'b0);
        send(16'h8000, 16'hFFFF, 2'b00, 1'b0);
        send(16'h8000, 16'hFFFF, 2'b10, 1'b0);
        send(16'h0000, 16'h8000, 2'b01, 1'b0);
        send(16'h0005, 16'h0003, 2'b01, 1'b0);
        send(16'h0000, 16'h8000, 2'b11, 1'b0);

        // Output stall: result held, input ignored, then released.
        rmode = 1;
        send(16'h1234, 16'h0001, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            x = WIDTH'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(result), 32'h1235);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rmode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);
        rmode = 0;
        send(16'h0001, 16'h0001, 2'b00, 1'b0);

        // Asynchronous reset in the middle of the SAT state.
        wait_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = 16'h7000;
        y = 16'h2000;
        mode = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_result", 32'(result), 32'd0);
        chk("async_ovf", 32'(ovf), 32'd0);
        chk("async_ovf_neg", 32'(ovf_neg), 32'd0);
        chk("async_sticky", 32'(sticky_ovf), 32'd0);
        chk("async_count", 32'(ovf_count), 32'd0);
        m_sticky = 1'b0;
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        // Counter saturation, clear coinciding with an event, then a lone clear.
        for (int i = 0; i < 5; i++) send(16'h7FFF, 16'h0001, 2'b00, 1'b0);
        wait_idle();
        chk("count_saturated", 32'(ovf_count), 32'd3);
        send(16'h8000, 16'h0001, 2'b01, 1'b1);
        wait_idle();
        chk("clr_event_sticky", 32'(sticky_ovf), 32'd1);
        chk("clr_event_count", 32'(ovf_count), 32'd1);
        clear_flags();

        for (int i = 0; i < 150; i++) begin
            xv = ($urandom_range(0, 2) == 0) ? ext[$urandom_range(0, 4)] : WIDTH'($urandom);
            yv = ($urandom_range(0, 2) == 0) ? ext[$urandom_range(0, 4)] : WIDTH'($urandom);
            send(xv, yv, 2'($urandom), ($urandom_range(0, 15) == 0));
            if (i % 40 == 39) clear_flags();
        end

        rmode = 2;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
